// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller:
// state encoding, default widths and the load-use compare.
package hazard_pkg;

    localparam int HZ_REG_ADDR_W = 3;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_LU    = 2'd1;
    localparam logic [1:0] S_MEM   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    // Load-use hazard from the per-operand address matches.
    function automatic logic lu_hit(
        input logic ld,
        input logic wb,
        input logic v1,
        input logic eq1,
        input logic v2,
        input logic eq2
    );
        return ld & wb & ((v1 & eq1) | (v2 & eq2));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-facing signal bundle of the hazard/stall controller.
// slave = controller side, master = pipeline/testbench side.
interface hazard_stall_ctrl_if #(
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_src1_valid;
    logic                  id_src2_valid;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_load;
    logic                  ex_wb_en;
    logic                  branch_taken;
    logic                  mem_req;
    logic                  mem_ready;
    logic                  freeze;
    logic                  bubble;
    logic                  flush_if_id;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      stall_cnt;

    modport slave (
        input  id_src1, id_src2, id_src1_valid, id_src2_valid,
        input  ex_dest, ex_load, ex_wb_en, branch_taken,
        input  mem_req, mem_ready,
        output freeze, bubble, flush_if_id, mem_timeout, stall_cnt
    );

    modport master (
        output id_src1, id_src2, id_src1_valid, id_src2_valid,
        output ex_dest, ex_load, ex_wb_en, branch_taken,
        output mem_req, mem_ready,
        input  freeze, bubble, flush_if_id, mem_timeout, stall_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Enabled up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    // Count enabled cycles, hold once saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_en && (r_cnt != {W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller: drives freeze/bubble/flush
// for the IF/ID and ID/EX registers and counts stall cycles.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W        = HZ_REG_ADDR_W,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int MEM_TIMEOUT       = 15,
    parameter int CNT_W             = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_stall_ctrl_if.slave bus
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [3:0]      LOAD_RLD = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [3:0]      FLSH_RLD = 4'(FLUSH_CYCLES - 1);
    localparam logic [WC_W-1:0] WC_ONE   = WC_W'(1);
    localparam logic [WC_W-1:0] WC_MAX   = WC_W'(MEM_TIMEOUT);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nx;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nx;
    logic [WC_W-1:0]       r_wait;
    logic [WC_W-1:0]       w_wait_nx;
    logic                  r_timeout;
    logic                  w_timeout_nx;
    logic                  w_freeze;
    logic                  w_bubble;
    logic                  w_flush;
    logic                  w_lu;
    logic                  w_mem_stall;
    logic [REG_ADDR_W-1:0] w_src1;
    logic [REG_ADDR_W-1:0] w_src2;
    logic [REG_ADDR_W-1:0] w_dest;

    assign w_src1 = bus.id_src1;
    assign w_src2 = bus.id_src2;
    assign w_dest = bus.ex_dest;

    assign w_lu = lu_hit(bus.ex_load, bus.ex_wb_en,
                         bus.id_src1_valid, w_src1 == w_dest,
                         bus.id_src2_valid, w_src2 == w_dest);

    assign w_mem_stall = bus.mem_req & ~bus.mem_ready;

    // Next-state and pipeline-control decode.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_wait_nx    = r_wait;
        w_timeout_nx = r_timeout;
        w_freeze     = 1'b0;
        w_bubble     = 1'b0;
        w_flush      = 1'b0;
        unique case (1'b1)
            (r_state == S_RUN): begin
                if (bus.branch_taken) begin
                    w_flush  = 1'b1;
                    w_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nx = S_FLUSH;
                        w_cnt_nx   = FLSH_RLD;
                    end
                end else if (w_mem_stall) begin
                    w_freeze   = 1'b1;
                    w_state_nx = S_MEM;
                    w_wait_nx  = WC_ONE;
                end else if (w_lu) begin
                    w_freeze = 1'b1;
                    w_bubble = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        w_state_nx = S_LU;
                        w_cnt_nx   = LOAD_RLD;
                    end
                end
            end
            (r_state == S_LU): begin
                w_freeze = 1'b1;
                w_bubble = 1'b1;
                if (w_mem_stall) begin
                    w_state_nx = S_MEM;
                    w_wait_nx  = WC_ONE;
                end else if (r_cnt == 4'd1) begin
                    w_state_nx = S_RUN;
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            (r_state == S_MEM): begin
                w_freeze = ~bus.mem_ready;
                if (bus.mem_ready) begin
                    w_state_nx = S_RUN;
                end else if (r_wait == WC_MAX) begin
                    w_freeze     = 1'b0;
                    w_timeout_nx = 1'b1;
                    w_state_nx   = S_RUN;
                end else begin
                    w_wait_nx = r_wait + WC_ONE;
                end
            end
            (r_state == S_FLUSH): begin
                w_flush  = 1'b1;
                w_bubble = 1'b1;
                if (bus.branch_taken) begin
                    w_cnt_nx = FLSH_RLD;
                end else if (r_cnt == 4'd1) begin
                    w_state_nx = S_RUN;
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            default: w_state_nx = S_RUN;
        endcase
    end

    // State, down-counters and the sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_RUN;
            r_cnt     <= '0;
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_wait    <= w_wait_nx;
            r_timeout <= w_timeout_nx;
        end
    end

    // Controls are forced low the instant reset asserts.
    assign bus.freeze      = rst & w_freeze;
    assign bus.bubble      = rst & w_bubble;
    assign bus.flush_if_id = rst & w_flush;
    assign bus.mem_timeout = r_timeout;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (bus.freeze),
        .o_cnt (bus.stall_cnt)
    );
endmodule
